// File: rtl/mix_columns_sequencer.sv
// mix_columns_sequencer: runs the four AES state columns through an external
// word mix unit one column per cycle and reassembles the mixed state.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, encrypt      request (IDLE only) and direction, latched together
//   bypass              (MIXCOL_BYPASS_EN only) pass state_in straight through
//   state_in/state_out  128-bit state, column c = bits [127-32c -: 32]
//   busy, done          not-IDLE flag, one-cycle result-valid pulse
//   mc_in1..4, mc_ready, mc_encrypt   issue side to the word mix unit
//   mc_out1..4, mc_done               result side from the word mix unit
//
// Build option: define MIXCOL_BYPASS_EN to add the bypass port.

module mix_columns_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         encrypt,
`ifdef MIXCOL_BYPASS_EN
    input  logic         bypass,
`endif
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done,
    output logic [7:0]   mc_in1,
    output logic [7:0]   mc_in2,
    output logic [7:0]   mc_in3,
    output logic [7:0]   mc_in4,
    output logic         mc_ready,
    output logic         mc_encrypt,
    input  logic [7:0]   mc_out1,
    input  logic [7:0]   mc_out2,
    input  logic [7:0]   mc_out3,
    input  logic [7:0]   mc_out4,
    input  logic         mc_done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t       state_q;
    logic [127:0] data_q;
    logic [127:0] out_q;
    logic [1:0]   issue_cnt_q;
    logic [1:0]   cap_cnt_q;
    logic         enc_q;
    logic         done_q;
    logic         ready_q;
    logic [31:0]  mc_in_q;

    // One extra bit on the incremented counts flags "all four columns".
    logic [2:0]   issue_cnt_d;
    logic [2:0]   cap_cnt_d;
    logic [31:0]  cap_word;

    function automatic logic [31:0] col_of(input logic [127:0] s,
                                           input logic [1:0]   c);
        logic [31:0] w;
        case (c)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s,
                                             input logic [1:0]   c,
                                             input logic [31:0]  w);
        logic [127:0] r;
        r = s;
        case (c)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    always_comb begin
        issue_cnt_d = {1'b0, issue_cnt_q} + 3'd1;
        cap_cnt_d   = {1'b0, cap_cnt_q} + 3'd1;
        cap_word    = {mc_out1, mc_out2, mc_out3, mc_out4};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            out_q       <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            enc_q       <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            mc_in_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q      <= state_in;
                        enc_q       <= encrypt;
                        issue_cnt_q <= '0;
                        cap_cnt_q   <= '0;
`ifdef MIXCOL_BYPASS_EN
                        if (bypass) begin
                            out_q   <= state_in;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else
`endif
                        begin
                            state_q <= ISSUE;
                            ready_q <= 1'b1;
                            mc_in_q <= col_of(state_in, 2'd0);
                        end
                    end
                end
                ISSUE, DRAIN: begin
                    if (state_q == ISSUE) begin
                        issue_cnt_q <= issue_cnt_d[1:0];
                        if (issue_cnt_d[2]) begin
                            state_q <= DRAIN;
                            ready_q <= 1'b0;
                            mc_in_q <= '0;
                        end else begin
                            mc_in_q <= col_of(data_q, issue_cnt_d[1:0]);
                        end
                    end
                    // Capture wins over the issue-side transition above.
                    if (mc_done) begin
                        out_q     <= put_col(out_q, cap_cnt_q, cap_word);
                        cap_cnt_q <= cap_cnt_d[1:0];
                        if (cap_cnt_d[2]) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                            mc_in_q <= '0;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_out  = out_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign mc_ready   = ready_q;
    assign mc_encrypt = enc_q;
    assign mc_in1     = mc_in_q[31:24];
    assign mc_in2     = mc_in_q[23:16];
    assign mc_in3     = mc_in_q[15:8];
    assign mc_in4     = mc_in_q[7:0];

endmodule

// File: tb/tb_mix_columns_sequencer.sv
// tb_mix_columns_sequencer: directed and random checks of the column
// sequencer against a GF(2^8) MixColumns reference and a word mix unit model.

module tb_mix_columns_sequencer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         encrypt = 1'b0;
    logic         bypass = 1'b0;
    logic [127:0] state_in = '0;
    logic [127:0] state_out;
    logic         busy;
    logic         done;
    logic [7:0]   mc_in1, mc_in2, mc_in3, mc_in4;
    logic         mc_ready;
    logic         mc_encrypt;
    logic [7:0]   mc_out1, mc_out2, mc_out3, mc_out4;
    logic         mc_done;

    logic         unit_done = 1'b0;
    logic [31:0]  unit_res = '0;
    logic         extra_done = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [127:0] prev_out = '0;

    mix_columns_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .encrypt    (encrypt),
`ifdef MIXCOL_BYPASS_EN
        .bypass     (bypass),
`endif
        .state_in   (state_in),
        .state_out  (state_out),
        .busy       (busy),
        .done       (done),
        .mc_in1     (mc_in1),
        .mc_in2     (mc_in2),
        .mc_in3     (mc_in3),
        .mc_in4     (mc_in4),
        .mc_ready   (mc_ready),
        .mc_encrypt (mc_encrypt),
        .mc_out1    (mc_out1),
        .mc_out2    (mc_out2),
        .mc_out3    (mc_out3),
        .mc_out4    (mc_out4),
        .mc_done    (mc_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c,
                                            input logic enc);
        logic [7:0] a [4];
        logic [7:0] m [4];
        logic [7:0] r [4];
        for (int j = 0; j < 4; j++) a[j] = c[31-8*j -: 8];
        if (enc) begin
            m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1;
        end else begin
            m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9;
        end
        for (int i = 0; i < 4; i++) begin
            r[i] = 8'h00;
            for (int j = 0; j < 4; j++)
                r[i] = r[i] ^ gmul(a[j], m[(j - i + 4) % 4]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s,
                                               input logic enc);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = mix_col(s[127-32*c -: 32], enc);
        return r;
    endfunction

    function automatic logic [31:0] col_of(input logic [127:0] s, input int c);
        return s[127-32*c -: 32];
    endfunction

    // Word mix unit: result one cycle after each issue strobe.
    always @(posedge clk) begin
        unit_done <= mc_ready;
        unit_res  <= mix_col({mc_in1, mc_in2, mc_in3, mc_in4}, mc_encrypt);
    end
    assign {mc_out1, mc_out2, mc_out3, mc_out4} = unit_res;
    assign mc_done = unit_done | extra_done;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [127:0] s, input logic enc,
                          input logic [127:0] exp, input string tag);
        int nready;
        nready = 0;
        start = 1'b1; state_in = s; encrypt = enc;
        step();
        start = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        encrypt = ~enc;
        for (int k = 0; k < 7; k++) begin
            if (mc_ready === 1'b1) nready++;
            chk($sformatf("%s_busy%0d", tag, k), 128'(busy), 128'(k < 6));
            chk($sformatf("%s_done%0d", tag, k), 128'(done), 128'(k == 5));
            chk($sformatf("%s_mcin%0d", tag, k),
                128'({mc_in1, mc_in2, mc_in3, mc_in4}),
                128'((k < 4) ? col_of(s, k) : 32'h0));
            if (k == 0)
                chk({tag, "_mcenc"}, 128'(mc_encrypt), 128'(enc));
            if (k == 2)
                chk({tag, "_partial"}, state_out,
                    {exp[127:96], prev_out[95:0]});
            if (k < 6) step();
        end
        chk({tag, "_out"}, state_out, exp);
        chk({tag, "_nready"}, 128'(nready), 128'(4));
        prev_out = exp;
    endtask

    initial begin
        logic [127:0] s, e;
        int ndone;

        // Reset, with start held high in the last reset cycle.
        reset = 1'b1;
        step();
        step();
        start = 1'b1;
        step();
        chk("rst_out", state_out, 128'h0);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_ready", 128'(mc_ready), 128'(0));
        chk("rst_mcin", 128'({mc_in1, mc_in2, mc_in3, mc_in4}), 128'h0);
        chk("rst_mcenc", 128'(mc_encrypt), 128'(0));
        start = 1'b0;
        reset = 1'b0;

        // Stray mc_done in IDLE.
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
        chk("idle_mcdone_out", state_out, 128'h0);
        chk("idle_mcdone_busy", 128'(busy), 128'(0));

        // Known vectors.
        s = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        e = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        chk("ref_fwd", mix_state(s, 1'b1), e);
        run_op(s, 1'b1, e, "vec_fwd");
        run_op(e, 1'b0, s, "vec_inv");
        run_op({4{32'hd4d4d4d5}}, 1'b1, {4{32'hd5d5d7d6}}, "vec_d4");

        // Restart attempts while busy and in DONE; stray mc_done in DONE.
        s = {$urandom, $urandom, $urandom, $urandom};
        e = mix_state(s, 1'b1);
        ndone = 0;
        start = 1'b1; state_in = s; encrypt = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) ndone++;
            chk($sformatf("ign_busy%0d", k), 128'(busy), 128'(k < 6));
            if (k == 6) chk("ign_hold", state_out, e);
            if (k == 1) start = 1'b1;
            if (k == 2) start = 1'b0;
            if (k == 5) begin start = 1'b1; extra_done = 1'b1; end
            if (k == 6) begin start = 1'b0; extra_done = 1'b0; end
            if (k < 7) step();
        end
        chk("ign_ndone", 128'(ndone), 128'(1));
        chk("ign_out", state_out, e);
        prev_out = e;

        // Reset mid-operation.
        s = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1; state_in = s; encrypt = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_out", state_out, 128'h0);
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(0));
        chk("mid_rst_ready", 128'(mc_ready), 128'(0));
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        chk("mid_rst_ndone", 128'(ndone), 128'(0));
        chk("mid_rst_out2", state_out, 128'h0);
        prev_out = '0;
        s = {$urandom, $urandom, $urandom, $urandom};
        run_op(s, 1'b1, mix_state(s, 1'b1), "after_rst");

        // Random operations.
        for (int n = 0; n < 8; n++) begin
            logic en;
            s = {$urandom, $urandom, $urandom, $urandom};
            en = 1'($urandom_range(0, 1));
            run_op(s, en, mix_state(s, en), $sformatf("rnd%0d", n));
        end

`ifdef MIXCOL_BYPASS_EN
        s = 128'h00112233_44556677_8899aabb_ccddeeff;
        start = 1'b1; bypass = 1'b1; state_in = s; encrypt = 1'b1;
        step();
        start = 1'b0; bypass = 1'b0; state_in = '0;
        chk("byp_done", 128'(done), 128'(1));
        chk("byp_out", state_out, s);
        chk("byp_ready0", 128'(mc_ready), 128'(0));
        step();
        chk("byp_done1", 128'(done), 128'(0));
        chk("byp_busy1", 128'(busy), 128'(0));
        chk("byp_ready1", 128'(mc_ready), 128'(0));
        chk("byp_hold", state_out, s);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
